// File: rtl/immediate_encoder_pkg.sv
// Shared word width, FSM state encodings and the fixed 2-bit rotate used by the
// immediate encoder.
package immediate_encoder_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [WORD_W-1:0] rol2(input logic [WORD_W-1:0] x);
      return {x[WORD_W-3:0], x[WORD_W-1:WORD_W-2]};
   endfunction

endpackage

// File: rtl/immd_window_check.sv
// Combinational test of whether a rotated candidate fits in the low 8-bit window.
module immd_window_check
   import immediate_encoder_pkg::*;
(
   input  logic [WORD_W-1:0] candidate,
   output logic              fits,
   output logic [7:0]        imm8
);

   assign fits = (candidate[WORD_W-1:8] == '0);
   assign imm8 = candidate[7:0];

endmodule

// File: rtl/immediate_encoder.sv
// Encodes a 32-bit constant as an ARM-style rotated 8-bit immediate or a 12-bit
// memory offset, searching one rotation per cycle with a fixed 2-bit rotate.
module immediate_encoder
   import immediate_encoder_pkg::*;
#(
   parameter int REGISTER_LEN = WORD_W,
   parameter int ROT_STEPS    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [REGISTER_LEN-1:0] value,
   input  logic                    is_mem,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic [11:0]             shift_operand
);

   localparam logic [3:0] K_LAST = 4'(ROT_STEPS - 1);

   state_e                  state_q, state_d;
   logic [3:0]              k_q, k_d;
   logic [REGISTER_LEN-1:0] cand_q, cand_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    valid_q, valid_d;
   logic [11:0]             so_q, so_d;

   logic                    fits;
   logic [7:0]              imm8;

   immd_window_check u_window (
      .candidate (cand_q),
      .fits      (fits),
      .imm8      (imm8)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cand_d  = cand_q;
      valid_d = valid_q;
      so_d    = so_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cand_d = value;
               if (is_mem) begin
                  state_d = ST_DONE;
                  valid_d = (value[REGISTER_LEN-1:12] == '0);
                  so_d    = valid_d ? value[11:0] : 12'h000;
               end else begin
                  state_d = ST_SEARCH;
                  k_d     = 4'd0;
               end
            end
         end
         ST_SEARCH: begin
            // cand_q always holds value ROL (2*k_q), so the first hit is the smallest k
            if (fits) begin
               state_d = ST_DONE;
               valid_d = 1'b1;
               so_d    = {k_q, imm8};
            end else if (k_q == K_LAST) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               so_d    = 12'h000;
            end else begin
               k_d    = k_q + 4'd1;
               cand_d = rol2(cand_q);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         k_q     <= 4'd0;
         cand_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         so_q    <= 12'h000;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cand_q  <= cand_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         so_q    <= so_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign valid         = valid_q;
   assign shift_operand = so_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Scoreboard bench for immediate_encoder: directed vectors push expectations,
// a negedge monitor pops and checks each done pulse.
module tb_immediate_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] value = '0;
   logic        is_mem = 1'b0;
   logic        busy, done, valid;
   logic [11:0] shift_operand;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] value;
      logic        is_mem;
      logic        exp_valid;
      logic [11:0] exp_so;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   immediate_encoder #(.REGISTER_LEN(32), .ROT_STEPS(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .value         (value),
      .is_mem        (is_mem),
      .busy          (busy),
      .done          (done),
      .valid         (valid),
      .shift_operand (shift_operand)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_decode(input logic [11:0] so, input logic m);
      logic [63:0] d;
      if (m) return {20'h0, so};
      d = {24'h0, so[7:0], 24'h0, so[7:0]} >> (int'(so[11:8]) * 2);
      return d[31:0];
   endfunction

   // Monitor: a done seen at this negedge belongs to cycle cyc+1
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc + 1);
         end else begin
            mon_e = sb.pop_front();
            chk("done_cycle", cyc + 1, mon_e.exp_cyc);
            chk("valid", {31'h0, valid}, {31'h0, mon_e.exp_valid});
            chk("shift_operand", {20'h0, shift_operand}, {20'h0, mon_e.exp_so});
            if (valid)
               chk("decode", ref_decode(shift_operand, mon_e.is_mem), mon_e.value);
         end
      end
   end

   // Leaves the bench at the negedge right after the accepting edge (cycle T+1)
   task automatic issue(input logic [31:0] v, input logic m, input logic ev,
                        input logic [11:0] eso, input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      value  = v;
      is_mem = m;
      e.value = v; e.is_mem = m; e.exp_valid = ev; e.exp_so = eso;
      e.exp_cyc = cyc + 1 + lat;
      if (push) sb.push_back(e);
      @(negedge clk);
      start  = 1'b0;
      value  = ~v;
      is_mem = ~m;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      #2;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_so", {20'h0, shift_operand}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      issue(32'h0000_00FF, 1'b0, 1'b1, 12'h0FF, 2, 1'b1);  wait_idle();
      issue(32'hFF00_0000, 1'b0, 1'b1, 12'h4FF, 6, 1'b1);  wait_idle();
      issue(32'hF000_000F, 1'b0, 1'b1, 12'h2FF, 4, 1'b1);  wait_idle();
      issue(32'h0000_0040, 1'b0, 1'b1, 12'h040, 2, 1'b1);  wait_idle();
      issue(32'h0000_03FC, 1'b0, 1'b1, 12'hFFF, 17, 1'b1); wait_idle();
      issue(32'h0000_1000, 1'b1, 1'b0, 12'h000, 1, 1'b1);  wait_idle();
      issue(32'h0000_0000, 1'b1, 1'b1, 12'h000, 1, 1'b1);  wait_idle();

      // Unencodable: busy must stay high through cycles T+1..T+17
      issue(32'h0000_0101, 1'b0, 1'b0, 12'h000, 17, 1'b1);
      chk("busy_T1", {31'h0, busy}, 32'h1);
      for (int i = 2; i <= 17; i++) begin
         @(negedge clk);
         chk($sformatf("busy_T%0d", i), {31'h0, busy}, 32'h1);
      end
      @(negedge clk);
      chk("busy_T18", {31'h0, busy}, 32'h0);

      // Second start at T+3 while searching must be ignored
      issue(32'h0000_0101, 1'b0, 1'b0, 12'h000, 17, 1'b1);
      @(negedge clk);
      start = 1'b1; value = 32'h0000_00FF; is_mem = 1'b0;
      @(negedge clk);
      start = 1'b0; is_mem = 1'b1;
      wait_idle();

      issue(32'h0000_0FFF, 1'b1, 1'b1, 12'hFFF, 1, 1'b1);  wait_idle();

      // Reset mid-search: outputs clear at once, no done pulse follows
      issue(32'h0000_0101, 1'b0, 1'b0, 12'h000, 17, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_done", {31'h0, done}, 32'h0);
      chk("arst_valid", {31'h0, valid}, 32'h0);
      chk("arst_so", {20'h0, shift_operand}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      issue(32'h0000_0000, 1'b0, 1'b1, 12'h000, 2, 1'b1);  wait_idle();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by %0t expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/immediate_encoder.md
IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 Parameter REGISTER_LEN, default 32, data word width; only 32 is supported.
REQ-002 Parameter ROT_STEPS, default 16, number of rotate_imm candidates searched.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 value  input  32  constant to encode; captured on an accepted start.
REQ-007 is_mem  input  1  1 = 12-bit memory offset encoding; 0 = data-processing rotated immediate; captured with value.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking that the result is valid.
REQ-010 valid  output  1  1 = value is encodable; held until the next accepted start.
REQ-011 shift_operand  output  12  data processing: {rotate_imm[3:0], imm8[7:0]}; memory: offset[11:0]; held until the next accepted start.

Function
REQ-012 The block SHALL produce the inverse of the val2 operand decoder: a decode of shift_operand SHALL reproduce the captured value exactly.
- Data processing: imm8 ROR (2*rotate_imm).
- Memory: zero-extended offset.
REQ-013 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-014 IDLE + start + is_mem=0 SHALL capture value, clear rot counter k to 0, and go to SEARCH.
REQ-015 IDLE + start + is_mem=1 SHALL go to DONE.
- Result: valid = (value[31:12]==0).
- shift_operand = value[11:0] when valid, else 0.
REQ-016 In SEARCH, each cycle SHALL test candidate = value ROL (2*k).
- Match: candidate[31:8]==0 -> valid=1, shift_operand={k[3:0], candidate[7:0]}, go to DONE.
REQ-017 No match with k<15 SHALL increment k and stay in SEARCH.
- No match with k==15 -> valid=0, shift_operand=0, go to DONE.
REQ-018 The smallest matching k SHALL always be chosen; value 0 SHALL encode as 0x000 with valid=1.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency, with start sampled at edge T:
- Memory: done high in cycle T+1.
- Data processing: done high in cycle T+2+k, where k is the matched rotation, or 15 on failure.
- Worst case: T+17.
REQ-021 start while busy (SEARCH or DONE) SHALL be ignored; value and is_mem changes while busy SHALL have no effect.
REQ-022 valid and shift_operand SHALL change only on entry to DONE, or on reset.

Reset
REQ-023 rst low SHALL immediately force state=IDLE, k=0, busy=0, done=0, valid=0, shift_operand=0 and clear the captured value, regardless of clock.
REQ-024 Reset asserted mid-SEARCH SHALL abort the search with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-025 The shared Defines.v SHALL hold the REGISTER_LEN width and the IDLE/SEARCH/DONE state encodings.
REQ-026 One combinational sub-module, immd_window_check, SHALL perform the window test.
- Inputs: a 32-bit candidate.
- Outputs: fits = (candidate[31:8]==0) and imm8.
- The rotate-by-2 and counter SHALL remain in immediate_encoder.
REQ-027 No multi-bit shifter SHALL be used; only a fixed 2-bit left rotate per cycle.

Verification
REQ-028 Scenario 1: is_mem=0, value 0x000000FF -> done at T+2, valid=1, shift_operand=0x0FF.
REQ-029 Scenario 2: is_mem=0.
- value 0xFF000000 -> done at T+6, valid=1, shift_operand=0x4FF.
- value 0xF000000F -> done at T+4, valid=1, shift_operand=0x2FF.
REQ-030 Scenario 3: is_mem=0, value 0x00000101 (not encodable) -> done at T+17, valid=0, shift_operand=0x000, busy high T+1..T+17.
REQ-031 Scenario 4: is_mem=1.
- value 0x00000FFF -> done at T+1, valid=1, shift_operand=0xFFF.
- value 0x00001000 -> valid=0, shift_operand=0x000.
REQ-032 Scenario 5: start with value 0x00000101, second start with 0x000000FF at T+3 -> ignored; the first result is reported at T+17.
REQ-033 Scenario 6: rst low at T+5 of a 0x00000101 search -> outputs 0 asynchronously, no done pulse; the next start with 0x00000000 -> done at T'+2, valid=1, shift_operand=0x000.
REQ-034 Every scoreboard check SHALL decode shift_operand with the reference decode and compare against the captured value.
